// File: rtl/reg_mem_dp.sv
// rtl/reg_mem_dp.sv - simple-dual-port lane-masked memory with 1/2-cycle registered read
// Define REG_MEM_DP_CLEAR_EN to build the post-reset zeroing sweep (RESET -> CLEAR -> READY).
module reg_mem_dp #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_BITS    = 12,
  parameter int LANES        = 1,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_BITS-1:0]  i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [LANES-1:0]      i_wr_mask,
  input  logic                  i_rd_en,
  input  logic [ADDR_BITS-1:0]  i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_busy
);
  localparam int DEPTH  = 2**ADDR_BITS;
  localparam int LANE_W = DATA_WIDTH / LANES;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_clr_we;
  logic [ADDR_BITS-1:0]  w_clr_addr;
  logic [DATA_WIDTH-1:0] w_bitmask;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_wr_acc = i_wr_en && !r_busy;
  assign w_rd_acc = i_rd_en && !r_busy;

  always_comb begin
    w_bitmask = '0;
    for (int i = 0; i < LANES; i++) begin
      w_bitmask[i*LANE_W +: LANE_W] = {LANE_W{i_wr_mask[i]}};
    end
  end

  assign w_merged = (r_mem[i_wr_addr] & ~w_bitmask) | (i_wr_data & w_bitmask);

  // Write-first bypass only matters when both ports hit the same word on one edge
  assign w_rd_word = ((RDW_MODE == 1) && w_wr_acc && (i_wr_addr == i_rd_addr)) ?
                     w_merged : r_mem[i_rd_addr];

`ifdef REG_MEM_DP_CLEAR_EN
  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;
  state_t               r_state;
  logic [ADDR_BITS-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_state != S_READY) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == {ADDR_BITS{1'b1}}) begin
        r_state <= S_READY;
        r_busy  <= 1'b0;
      end else begin
        r_state <= S_CLEAR;
      end
    end
  end

  // The first edge after release already clears word 0, so the sweep takes exactly DEPTH edges
  assign w_clr_we   = (r_state != S_READY) && !i_rst;
  assign w_clr_addr = r_cnt;
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_busy <= 1'b1;
    else       r_busy <= 1'b0;
  end

  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (w_clr_we)      r_mem[w_clr_addr] <= '0;
    else if (w_wr_acc) r_mem[i_wr_addr]  <= w_merged;
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_p_data;
      logic                  r_p_valid;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_p_data   <= '0;
          r_p_valid  <= 1'b0;
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_p_valid  <= w_rd_acc;
          if (w_rd_acc) r_p_data <= w_rd_word;
          r_rd_valid <= r_p_valid;
          if (r_p_valid) r_rd_data <= r_p_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_rd_data <= w_rd_word;
        end
      end
    end
  endgenerate

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_busy     = r_busy;
endmodule

// File: tb/tb_reg_mem_dp.sv
// tb/tb_reg_mem_dp.sv - checks a read-first/latency-1 and a write-first/latency-2 instance
// Expected busy length follows REG_MEM_DP_CLEAR_EN the same way the design does.
module tb_reg_mem_dp;
`ifdef REG_MEM_DP_CLEAR_EN
  localparam int CLR_EDGES = 16;
  localparam bit HAS_CLR   = 1'b1;
`else
  localparam int CLR_EDGES = 1;
  localparam bit HAS_CLR   = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [15:0] d;
    bit          k;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_mask = '0;
  logic [15:0] d1_data, d2_data;
  logic        d1_valid, d2_valid, d1_busy, d2_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mm [16];
  bit          mk [16][2];
  ent_t        q1[$], q2[$];
  logic [15:0] h1 = '0, h2 = '0;
  bit          h1k = 1'b1, h2k = 1'b1;
  int          cyc = 0;
  int          since = 0;

  always #5 clk = ~clk;

  reg_mem_dp #(.DATA_WIDTH(16), .ADDR_BITS(4), .LANES(2), .READ_LATENCY(1), .RDW_MODE(0)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_wr_mask(wr_mask), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(d1_data), .o_rd_valid(d1_valid), .o_busy(d1_busy)
  );

  reg_mem_dp #(.DATA_WIDTH(16), .ADDR_BITS(4), .LANES(2), .READ_LATENCY(2), .RDW_MODE(1)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_wr_mask(wr_mask), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(d2_data), .o_rd_valid(d2_valid), .o_busy(d2_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: word-level memory with lane-known flags, reads become (due edge, value) entries
  always @(posedge clk) begin : model_cmp
    logic [15:0] ro, rn;
    bit          rok, rnk, v1, v2;
    cyc++;
    if (!rst) begin
      if (since >= CLR_EDGES) begin
        ro  = mm[rd_addr];
        rok = mk[rd_addr][0] && mk[rd_addr][1];
        if (wr_en) begin
          for (int l = 0; l < 2; l++) begin
            if (wr_mask[l]) begin
              mm[wr_addr][l*8 +: 8] = wr_data[l*8 +: 8];
              mk[wr_addr][l] = 1'b1;
            end
          end
        end
        rn  = mm[rd_addr];
        rnk = mk[rd_addr][0] && mk[rd_addr][1];
        if (rd_en) begin
          q1.push_back('{cyc, ro, rok});
          q2.push_back('{cyc + 1, rn, rnk});
        end
      end
      if (since < CLR_EDGES) begin
        since++;
        if (HAS_CLR && since == CLR_EDGES) begin
          for (int a = 0; a < 16; a++) begin
            mm[a] = '0;
            mk[a][0] = 1'b1;
            mk[a][1] = 1'b1;
          end
        end
      end
    end else begin
      since = 0;
    end

    #1;
    if (rst) begin
      q1.delete();
      q2.delete();
      h1 = '0; h1k = 1'b1;
      h2 = '0; h2k = 1'b1;
    end
    chk("busy_d1", d1_busy, rst || (since < CLR_EDGES));
    chk("busy_d2", d2_busy, rst || (since < CLR_EDGES));
    v1 = (q1.size() > 0) && (q1[0].due == cyc);
    if (v1) begin h1 = q1[0].d; h1k = q1[0].k; void'(q1.pop_front()); end
    v2 = (q2.size() > 0) && (q2[0].due == cyc);
    if (v2) begin h2 = q2[0].d; h2k = q2[0].k; void'(q2.pop_front()); end
    chk("valid_d1", d1_valid, v1);
    chk("valid_d2", d2_valid, v2);
    if (h1k) chk("data_d1", d1_data, h1);
    if (h2k) chk("data_d2", d2_data, h2);
  end

  task automatic drive(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] wm, input bit re, input logic [3:0] ra);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
    rd_en = re; rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
  endtask

  // Counts rising edges with busy high after release, poking a write at addr 7 meanwhile
  task automatic count_busy(output int edges);
    edges = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!d1_busy) begin
        wr_en = 1'b0;
        break;
      end
      edges++;
    end
  endtask

  initial begin : stim
    int          e;
    logic [5:0]  vbits;
    logic [63:0] dq;
    logic [15:0] pat;
    bit          sv [7];
    logic [3:0]  sa [7];

    repeat (3) @(negedge clk);
    chk("reset_rd_data", d1_data, 16'h0);
    chk("reset_rd_valid", d2_valid, 1'b0);
    chk("reset_busy", d1_busy, 1'b1);

    rst = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hFFFF; wr_mask = 2'b11;
    rst = 1'b0;
    count_busy(e);
    chk("busy_edges_after_midsweep_reset", e, CLR_EDGES);

    for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
    idle();
    idle();
`ifdef REG_MEM_DP_CLEAR_EN
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd7);
    idle();
    chk("addr7_cleared_d1", d1_data, 16'h0000);
    idle();
    chk("addr7_cleared_d2", d2_data, 16'h0000);
`endif

    for (int i = 0; i < 16; i++) begin
      pat = 16'hC000 + 16'(i * 257);
      drive(1'b1, 4'(i), pat, 2'b11, 1'b0, 4'd0);
    end
    idle();

    sv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    sa = '{4'd0, 4'd1, 4'd0, 4'd2, 4'd3, 4'd0, 4'd0};
    vbits = '0;
    dq    = '0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        vbits[j-1] = d2_valid;
        if (d2_valid) dq = {dq[47:0], d2_data};
      end
      rd_en = sv[j]; rd_addr = sa[j];
    end
    chk("stream_valid_pattern", vbits, 6'b110110);
    chk("stream_data_order", dq, 64'hC000C101C202C303);

    drive(1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0, 4'd0);
    drive(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
    idle();
    chk("mask_d1_lat1", d1_data, 16'hAB34);
    chk("mask_d1_valid", d1_valid, 1'b1);
    chk("mask_d2_early", d2_valid, 1'b0);
    idle();
    chk("mask_d2_lat2", d2_data, 16'hAB34);
    chk("mask_d2_valid", d2_valid, 1'b1);
    chk("model_addr3", mm[3], 16'hAB34);
    drive(1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
    idle();
    idle();
    chk("mask_zero_d2", d2_data, 16'hAB34);

    drive(1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0);
    drive(1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5);
    idle();
    chk("rdw_read_first", d1_data, 16'h1111);
    idle();
    chk("rdw_write_first", d2_data, 16'h2222);
    chk("rd_data_holds", d1_data, 16'h1111);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
    idle();
    chk("rdw_next_d1", d1_data, 16'h2222);
    idle();
    chk("rdw_next_d2", d2_data, 16'h2222);

    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2);
    @(negedge clk);
    rd_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("inflight_discard_valid", d2_valid, 1'b0);
    chk("inflight_discard_data", d2_data, 16'h0);
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hFFFF; wr_mask = 2'b11;
    count_busy(e);
    chk("busy_edges_final", e, CLR_EDGES);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
